// File: rtl/bus_cycle_pkg.sv
// Shared FSM state encoding, timeout read value and counter sizing helper
// for the bus-cycle generator.
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Sliced down to DW bits at the point of use.
  localparam logic [63:0] RD_TIMEOUT_VAL = '1;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bus_phase_cnt.sv
// Loadable down-counter with zero flag; one instance times every phase
// (setup, strobe, hold) of a bus cycle. Holds at zero until reloaded.
module bus_phase_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bus_cycle_gen.sv
// Single-word read/write bus-cycle generator feeding the address decoder.
// Registered outputs; CS always returns high for at least one cycle per transfer.
module bus_cycle_gen
  import bus_cycle_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int MAX_WAIT   = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] addr,
  output logic          CS,
  output logic          rd_n,
  output logic          wr_n,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_wait
);

  localparam int PMAX = (SETUP_CYC > STROBE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = cnt_width(PMAX);
  localparam int WW = $clog2(MAX_WAIT + 1);

  state_t        r_state, w_state_nxt;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_zero;
  logic [WW-1:0] r_wcnt, w_wcnt_nxt;
  logic          r_we;
  logic          r_to_pend, w_to_pend_nxt;
  logic          w_accept, w_cap_rd, w_done_nxt, w_to_nxt;
  logic [DW-1:0] w_rdata_nxt;

  logic          r_busy, r_done, r_timeout, r_cs, r_rd_n, r_wr_n, r_oe;
  logic [DW-1:0] r_rdata, r_wdata;
  logic [AW-1:0] r_addr;

  bus_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_load_val    = '0;
    w_wcnt_nxt    = r_wcnt;
    w_to_pend_nxt = r_to_pend;
    w_accept      = 1'b0;
    w_cap_rd      = 1'b0;
    w_done_nxt    = 1'b0;
    w_to_nxt      = 1'b0;
    w_rdata_nxt   = bus_rdata;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept      = 1'b1;
          w_state_nxt   = ST_SETUP;
          w_load        = 1'b1;
          w_load_val    = CW'(SETUP_CYC - 1);
          w_to_pend_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_zero) begin
          w_state_nxt = ST_STROBE;
          w_load      = 1'b1;
          w_load_val  = CW'(STROBE_CYC - 1);
          w_wcnt_nxt  = '0;
        end
      end
      ST_STROBE: begin
        // Minimum strobe elapsed: extend while the peripheral waits, up to the limit.
        if (w_zero) begin
          if (bus_wait && (r_wcnt != WW'(MAX_WAIT))) begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end else begin
            w_state_nxt   = ST_HOLD;
            w_load        = 1'b1;
            w_load_val    = CW'(HOLD_CYC - 1);
            w_to_pend_nxt = bus_wait;
            w_cap_rd      = !r_we;
            w_rdata_nxt   = bus_wait ? RD_TIMEOUT_VAL[DW-1:0] : bus_rdata;
          end
        end
      end
      ST_HOLD: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_to_nxt    = r_to_pend;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= '0;
      r_we      <= 1'b0;
      r_to_pend <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cs      <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_to_pend <= w_to_pend_nxt;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= we;
      end
      if (w_cap_rd) begin
        r_rdata <= w_rdata_nxt;
      end
      // Bus controls are decoded from the next state so they change on the transition edge.
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_timeout <= w_to_nxt;
      r_cs      <= (w_state_nxt == ST_IDLE);
      r_rd_n    <= !((w_state_nxt == ST_STROBE) && !r_we);
      r_wr_n    <= !((w_state_nxt == ST_STROBE) && r_we);
      r_oe      <= (w_state_nxt != ST_IDLE) && (w_accept ? we : r_we);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign rdata     = r_rdata;
  assign addr      = r_addr;
  assign CS        = r_cs;
  assign rd_n      = r_rd_n;
  assign wr_n      = r_wr_n;
  assign bus_wdata = r_wdata;
  assign bus_oe    = r_oe;

endmodule
